// File: rtl/alioth_test_monitor_pkg.sv
// -----------------------------------------------------------------------------
// alioth_test_monitor_pkg
//   Shared types and default constants for the alioth test-completion monitor.
//   - mon_state_t : monitor state encoding as seen on state_o
//                   (0 RUN, 1 DONE, 2 TIMEOUT)
//   - DEFAULT_*   : default parameter values for alioth_test_monitor
// -----------------------------------------------------------------------------
package alioth_test_monitor_pkg;

   typedef enum logic [1:0] {
      MON_RUN     = 2'd0,
      MON_DONE    = 2'd1,
      MON_TIMEOUT = 2'd2
   } mon_state_t;

   localparam logic [31:0] DEFAULT_TOHOST_PC   = 32'h0000_00a0;
   localparam int          DEFAULT_TOHOST_HITS = 8;
   localparam logic [31:0] DEFAULT_PASS_VALUE  = 32'd1;
   localparam int          DEFAULT_TIMEOUT_BIT = 20;

   // Width of the to-host arrival counter (hit_cnt_o).
   localparam int HIT_CNT_WIDTH = 8;

endpackage

// File: rtl/alioth_popcount.sv
// -----------------------------------------------------------------------------
// alioth_popcount
//   Combinational population count of the per-lane retire strobes.
//   Parameters:
//     N     : number of input bits (retire lanes)
//   Ports:
//     bits  in  N              : lane strobes
//     count out $clog2(N+1)    : number of set bits
// -----------------------------------------------------------------------------
module alioth_popcount #(
   parameter  int N = 2,
   localparam int W = $clog2(N + 1)
) (
   input  logic [N-1:0] bits,
   output logic [W-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < N; i++) begin
         count = count + W'(bits[i]);
      end
   end

endmodule

// File: rtl/alioth_test_monitor.sv
// -----------------------------------------------------------------------------
// alioth_test_monitor
//   Test-completion and performance monitor for the alioth core. Watches the
//   fetch PC for repeated, distinct arrivals at the to-host PC, then latches a
//   pass/fail verdict from the test-result register and freezes its cycle and
//   instruction counters.
//
//   Build option: define ALIOTH_TEST_MONITOR_TIMEOUT_EN to enable timeout
//   detection (cycle_cnt[TIMEOUT_BIT] set ends the test in TIMEOUT). When it
//   is undefined, timeout_o is tied 0, the cycle counter free-runs and wraps,
//   and the monitor stays in RUN until the hit count is reached.
//
//   Ports:
//     clk            in  1            clock
//     rst_n          in  1            asynchronous active-low reset
//     clear_i        in  1            synchronous restart to RUN, counters zeroed
//     pc_i           in  PC_WIDTH     current fetch PC
//     retire_valid_i in  RETIRE_PORTS per-lane retire strobes
//     result_i       in  32           test-result register (x3)
//     state_o        out 2            0 RUN, 1 DONE, 2 TIMEOUT
//     done_o         out 1            test ended by to-host hits
//     pass_o         out 1            done and result matched PASS_VALUE
//     timeout_o      out 1            test ended by timeout
//     hit_cnt_o      out 8            to-host arrivals so far
//     cycle_cnt_o    out CNT_WIDTH    cycles spent in RUN
//     inst_cnt_o     out CNT_WIDTH    retired instructions (saturating)
//     end_cycle_o    out CNT_WIDTH    cycle count at the first to-host hit
//     fail_num_o     out 32           result_i sampled at test end
// -----------------------------------------------------------------------------
module alioth_test_monitor
   import alioth_test_monitor_pkg::*;
#(
   parameter int          PC_WIDTH     = 32,
   parameter int          CNT_WIDTH    = 32,
   parameter int          RETIRE_PORTS = 2,
   parameter logic [31:0] TOHOST_PC    = DEFAULT_TOHOST_PC,
   parameter int          TOHOST_HITS  = DEFAULT_TOHOST_HITS,
   parameter logic [31:0] PASS_VALUE   = DEFAULT_PASS_VALUE,
   parameter int          TIMEOUT_BIT  = DEFAULT_TIMEOUT_BIT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear_i,
   input  logic [PC_WIDTH-1:0]     pc_i,
   input  logic [RETIRE_PORTS-1:0] retire_valid_i,
   input  logic [31:0]             result_i,
   output logic [1:0]              state_o,
   output logic                    done_o,
   output logic                    pass_o,
   output logic                    timeout_o,
   output logic [7:0]              hit_cnt_o,
   output logic [CNT_WIDTH-1:0]    cycle_cnt_o,
   output logic [CNT_WIDTH-1:0]    inst_cnt_o,
   output logic [CNT_WIDTH-1:0]    end_cycle_o,
   output logic [31:0]             fail_num_o
);

   localparam int                  POP_W       = $clog2(RETIRE_PORTS + 1);
   localparam int                  SUM_W       = CNT_WIDTH + 1;
   localparam logic [PC_WIDTH-1:0] TOHOST_PC_W = PC_WIDTH'(TOHOST_PC);
   localparam logic [HIT_CNT_WIDTH-1:0] LAST_HIT_IDX = HIT_CNT_WIDTH'(TOHOST_HITS - 1);

   mon_state_t                state_reg, state_next;
   logic [CNT_WIDTH-1:0]      cycle_reg, cycle_next;
   logic [CNT_WIDTH-1:0]      inst_reg, inst_next;
   logic [CNT_WIDTH-1:0]      end_cycle_reg, end_cycle_next;
   logic [HIT_CNT_WIDTH-1:0]  hit_reg, hit_next;
   logic [PC_WIDTH-1:0]       last_pc_reg, last_pc_next;
   logic [31:0]               fail_num_reg, fail_num_next;
   logic                      pass_reg, pass_next;

   logic [POP_W-1:0]          retire_count;
   logic [SUM_W-1:0]          inst_sum;
   logic                      hit;
   logic                      final_hit;
   logic                      timeout_hit;

   alioth_popcount #(
      .N     (RETIRE_PORTS)
   ) u_popcount (
      .bits  (retire_valid_i),
      .count (retire_count)
   );

   // A hit is an arrival: the PC must have changed into TOHOST_PC, so a PC
   // parked on the to-host loop counts only once.
   assign hit       = (pc_i == TOHOST_PC_W) && (pc_i != last_pc_reg);
   assign final_hit = hit && (hit_reg == LAST_HIT_IDX);

   // One extra bit catches the carry so the instruction count can saturate.
   assign inst_sum  = {1'b0, inst_reg} + SUM_W'(retire_count);

`ifdef ALIOTH_TEST_MONITOR_TIMEOUT_EN
   assign timeout_hit = cycle_reg[TIMEOUT_BIT];
`else
   // Timeout compiled out: constant 0 for any legal TIMEOUT_BIT, which keeps
   // the parameter referenced in this build without creating any logic.
   assign timeout_hit = (TIMEOUT_BIT < 0);
`endif

   always_comb begin
      state_next     = state_reg;
      cycle_next     = cycle_reg;
      inst_next      = inst_reg;
      end_cycle_next = end_cycle_reg;
      hit_next       = hit_reg;
      last_pc_next   = last_pc_reg;
      fail_num_next  = fail_num_reg;
      pass_next      = pass_reg;

      if (clear_i) begin
         // Restart wins over everything, including this edge's hit/retire.
         state_next     = MON_RUN;
         cycle_next     = '0;
         inst_next      = '0;
         end_cycle_next = '0;
         hit_next       = '0;
         last_pc_next   = '0;
         fail_num_next  = '0;
         pass_next      = 1'b0;
      end else if (state_reg == MON_RUN) begin
         cycle_next   = cycle_reg + 1'b1;
         inst_next    = inst_sum[CNT_WIDTH] ? '1 : inst_sum[CNT_WIDTH-1:0];
         last_pc_next = pc_i;

         if (hit) begin
            hit_next = hit_reg + 1'b1;
            if (hit_reg == '0) begin
               end_cycle_next = cycle_reg;
            end
         end

         // The final hit takes precedence over a timeout on the same edge.
         if (final_hit) begin
            state_next    = MON_DONE;
            fail_num_next = result_i;
            pass_next     = (result_i == PASS_VALUE);
         end else if (timeout_hit) begin
            state_next    = MON_TIMEOUT;
            fail_num_next = result_i;
         end
      end
      // DONE and TIMEOUT hold every register until clear_i or rst_n.
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= MON_RUN;
         cycle_reg     <= '0;
         inst_reg      <= '0;
         end_cycle_reg <= '0;
         hit_reg       <= '0;
         last_pc_reg   <= '0;
         fail_num_reg  <= '0;
         pass_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cycle_reg     <= cycle_next;
         inst_reg      <= inst_next;
         end_cycle_reg <= end_cycle_next;
         hit_reg       <= hit_next;
         last_pc_reg   <= last_pc_next;
         fail_num_reg  <= fail_num_next;
         pass_reg      <= pass_next;
      end
   end

   assign state_o     = state_reg;
   assign done_o      = (state_reg == MON_DONE);
   assign pass_o      = pass_reg;
   assign hit_cnt_o   = hit_reg;
   assign cycle_cnt_o = cycle_reg;
   assign inst_cnt_o  = inst_reg;
   assign end_cycle_o = end_cycle_reg;
   assign fail_num_o  = fail_num_reg;

`ifdef ALIOTH_TEST_MONITOR_TIMEOUT_EN
   assign timeout_o = (state_reg == MON_TIMEOUT);
`else
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_alioth_test_monitor.sv
// -----------------------------------------------------------------------------
// tb_alioth_test_monitor
//   Self-checking bench for alioth_test_monitor. Main instance uses an 8-bit
//   counter and TIMEOUT_BIT=6 so saturation, wrap and timeout are reachable;
//   a second instance with TOHOST_PC=0 covers the PC-0-after-reset case.
//   Honours ALIOTH_TEST_MONITOR_TIMEOUT_EN like the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alioth_test_monitor;

   localparam int          PCW    = 32;
   localparam int          CW     = 8;
   localparam int          RP     = 3;
   localparam int          HITS   = 8;
   localparam int          TO_BIT = 6;
   localparam logic [31:0] TOHOST = 32'h0000_00a0;
   localparam int          MAXC   = (1 << CW) - 1;
`ifdef ALIOTH_TEST_MONITOR_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           clear = 1'b0;
   logic [PCW-1:0] pc = '0;
   logic [PCW-1:0] pc0 = '0;
   logic [RP-1:0]  rv = '0;
   logic [31:0]    result = '0;

   logic [1:0]     state_o, state0;
   logic           done_o, pass_o, timeout_o, done0, pass0, timeout0;
   logic [7:0]     hit_o, hit0;
   logic [CW-1:0]  cycle_o, inst_o, end_o, cycle0, inst0, end0;
   logic [31:0]    fail_o, fail0;

   int total = 0;
   int bad   = 0;

   // Reference model state, stepped once per sampled clock edge.
   int          m_state, m_cycle, m_inst, m_hits, m_end;
   logic [31:0] m_last_pc, m_fail;
   bit          m_pass;

   typedef struct {
      logic [RP-1:0] rv;
      int            exp_inst;
      int            exp_cycle;
   } vec_t;
   vec_t vecs [15];

   always #5 clk = ~clk;

   alioth_test_monitor #(
      .PC_WIDTH(PCW), .CNT_WIDTH(CW), .RETIRE_PORTS(RP), .TOHOST_PC(TOHOST),
      .TOHOST_HITS(HITS), .PASS_VALUE(32'd1), .TIMEOUT_BIT(TO_BIT)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .clear_i(clear), .pc_i(pc), .retire_valid_i(rv),
      .result_i(result), .state_o(state_o), .done_o(done_o), .pass_o(pass_o),
      .timeout_o(timeout_o), .hit_cnt_o(hit_o), .cycle_cnt_o(cycle_o),
      .inst_cnt_o(inst_o), .end_cycle_o(end_o), .fail_num_o(fail_o)
   );

   alioth_test_monitor #(
      .PC_WIDTH(PCW), .CNT_WIDTH(CW), .RETIRE_PORTS(RP), .TOHOST_PC(32'h0),
      .TOHOST_HITS(1), .PASS_VALUE(32'd1), .TIMEOUT_BIT(TO_BIT)
   ) u_dut0 (
      .clk(clk), .rst_n(rst_n), .clear_i(clear), .pc_i(pc0), .retire_valid_i(rv),
      .result_i(result), .state_o(state0), .done_o(done0), .pass_o(pass0),
      .timeout_o(timeout0), .hit_cnt_o(hit0), .cycle_cnt_o(cycle0),
      .inst_cnt_o(inst0), .end_cycle_o(end0), .fail_num_o(fail0)
   );

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_cycle = 0; m_inst = 0; m_hits = 0; m_end = 0;
      m_last_pc = '0; m_fail = '0; m_pass = 1'b0;
   endtask

   // Behavioural rules: count cycles/instructions while running, an arrival is
   // a change of PC onto the to-host address, the HITS-th arrival ends the test.
   task automatic model_step();
      int old_cycle;
      bit is_hit;
      if (clear) begin
         model_reset();
         return;
      end
      if (m_state != 0) return;
      old_cycle = m_cycle;
      is_hit    = (pc == TOHOST) && (pc != m_last_pc);
      m_cycle   = (m_cycle + 1) % (1 << CW);
      m_inst    = m_inst + $countones(rv);
      if (m_inst > MAXC) m_inst = MAXC;
      m_last_pc = pc;
      if (is_hit) begin
         if (m_hits == 0) m_end = old_cycle;
         m_hits++;
      end
      if (is_hit && m_hits == HITS) begin
         m_state = 1; m_fail = result; m_pass = (result == 32'd1);
      end else if (TO_EN && old_cycle >= (1 << TO_BIT)) begin
         m_state = 2; m_fail = result;
      end
   endtask

   task automatic check_model();
      check("state",     state_o,   m_state);
      check("done",      done_o,    m_state == 1);
      check("pass",      pass_o,    m_pass);
      check("timeout",   timeout_o, m_state == 2);
      check("hit_cnt",   hit_o,     m_hits);
      check("cycle_cnt", cycle_o,   m_cycle);
      check("inst_cnt",  inst_o,    m_inst);
      check("end_cycle", end_o,     m_end);
      check("fail_num",  fail_o,    m_fail);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_state"},   state_o,   0);
      check({tag, "_done"},    done_o,    0);
      check({tag, "_pass"},    pass_o,    0);
      check({tag, "_timeout"}, timeout_o, 0);
      check({tag, "_hit"},     hit_o,     0);
      check({tag, "_cycle"},   cycle_o,   0);
      check({tag, "_inst"},    inst_o,    0);
      check({tag, "_end"},     end_o,     0);
      check({tag, "_fail"},    fail_o,    0);
   endtask

   // Inputs are set at the falling edge; outputs are compared at the next one.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model();
   endtask

   task automatic do_clear();
      clear = 1'b1; pc = TOHOST; rv = '1;
      tick();
      clear = 1'b0;
      check_zero("clear");
   endtask

   task automatic run_table();
      pc = 32'h100;
      for (int i = 0; i < 15; i++) begin
         rv = vecs[i].rv;
         tick();
         check("tbl_inst",  inst_o,  vecs[i].exp_inst);
         check("tbl_cycle", cycle_o, vecs[i].exp_cycle);
      end
   endtask

   // Table phase, idle to cycle 40, then HITS separate arrivals two cycles apart.
   task automatic run_arrivals(input logic [31:0] res);
      result = res;
      run_table();
      rv = '0; pc = 32'h200;
      repeat (25) tick();
      for (int k = 0; k < HITS; k++) begin
         pc = TOHOST;     tick();
         pc = 32'h204;    tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 15; i++) begin
         vecs[i].rv        = (i < 10) ? 3'b011 : 3'b001;
         vecs[i].exp_inst  = (i < 10) ? 2 * (i + 1) : 20 + (i - 9);
         vecs[i].exp_cycle = i + 1;
      end

      model_reset();
      pc = 32'h100;
      repeat (2) @(negedge clk);
      check_zero("reset");
      check("d0_reset_state", state0, 0);
      rst_n = 1'b1;
      $display("phase reset: checked");

      // TOHOST_PC = 0: PC 0 right after reset matches last_pc, no hit.
      pc0 = '0;
      repeat (3) begin
         tick();
         check("d0_hold_hit",   hit0,   0);
         check("d0_hold_state", state0, 0);
      end
      pc0 = 32'h4; tick();
      pc0 = 32'h0; tick();
      check("d0_hit",  hit0,  1);
      check("d0_done", done0, 1);
      check("d0_end",  end0,  4);
      $display("phase tohost_pc_zero: checked");

      // Passing run, then 100 frozen cycles of noisy inputs.
      do_clear();
      run_arrivals(32'd1);
      check("p_done", done_o, 1);
      check("p_pass", pass_o, 1);
      check("p_end",  end_o,  40);
      check("p_hit",  hit_o,  8);
      check("p_inst", inst_o, 25);
      for (int i = 0; i < 100; i++) begin
         pc = (i % 2 == 0) ? TOHOST : $urandom; rv = '1; result = $urandom;
         tick();
      end
      check("p_frozen_cycle", cycle_o, 55);
      check("p_frozen_hit",   hit_o,   8);
      check("p_frozen_fail",  fail_o,  1);
      $display("phase pass_run: checked");

      // Clear in DONE, then the same sequence with a failing result.
      do_clear();
      run_arrivals(32'd5);
      check("f_done",  done_o, 1);
      check("f_pass",  pass_o, 0);
      check("f_fail",  fail_o, 5);
      check("f_end",   end_o,  40);
      check("f_cycle", cycle_o, 55);
      $display("phase fail_run: checked");

      // PC parked on the to-host address counts one arrival.
      do_clear();
      pc = TOHOST; rv = '0;
      repeat (20) tick();
      check("held_hit", hit_o, 1);
      pc = 32'h300; tick();
      check("held_hit_after", hit_o, 1);
      $display("phase held_pc: checked");

      // Asynchronous reset mid-RUN, then an identical recount.
      do_clear();
      pc = 32'h100; rv = 3'b001;
      repeat (10) tick();
      #2 rst_n = 1'b0;
      #1 check_zero("async_rst");
      model_reset();
      @(negedge clk);
      check_zero("async_rst_held");
      rst_n = 1'b1;
      run_table();
      $display("phase async_reset: checked");

      // Timeout boundary at cycle 64.
      do_clear();
      pc = 32'h300; rv = '0;
      repeat (64) tick();
      check("to_cycle64",   cycle_o,   64);
      check("to_before",    timeout_o, 0);
      tick();
      check("to_after",     timeout_o, TO_EN);
      check("to_state",     state_o,   TO_EN ? 2 : 0);
      $display("phase timeout: checked");

      // Final hit on the same edge as the timeout: DONE wins.
      do_clear();
      pc = 32'h300; result = 32'd1;
      repeat (50) tick();
      for (int k = 0; k < HITS; k++) begin
         pc = TOHOST;  tick();
         pc = 32'h304; tick();
      end
      check("tie_state",   state_o,   1);
      check("tie_timeout", timeout_o, 0);
      check("tie_pass",    pass_o,    1);
      $display("phase done_wins: checked");

      // Saturation of inst_cnt and wrap of cycle_cnt (timeout freezes them instead).
      do_clear();
      pc = 32'h300; rv = '1;
      repeat (100) tick();
      check("sat_inst", inst_o, TO_EN ? 195 : 255);
      rv = '0;
      repeat (160) tick();
      check("wrap_cycle", cycle_o, TO_EN ? 65 : 4);
      $display("phase saturate_wrap: checked");

      // Randomized traffic against the model.
      do_clear();
      for (int i = 0; i < 600; i++) begin
         clear = ($urandom_range(0, 59) == 0);
         case ($urandom_range(0, 2))
            0:       pc = TOHOST;
            1:       pc = 32'h1000;
            default: pc = $urandom;
         endcase
         rv     = RP'($urandom);
         result = ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom;
         tick();
      end
      clear = 1'b0;
      $display("phase random: checked");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
